// File: rtl/vdf_3_seq.sv
// Sequencer for the three-stage gated DFF pipeline. It tracks operations through the stages,
// drives the stage gates in each operation's slot and buffers the pipeline outputs in a FIFO.
module vdf_3_seq #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       REQ_V,
    output logic       REQ_RDY,
    input  logic [1:0] REQ_OP,
    input  logic [2:0] REQ_MASK,
    output logic       D,
    output logic       E,
    output logic       C,
    output logic       B,
    output logic       A,
    input  logic       OUT,
    output logic       RES_V,
    input  logic       RES_RDY,
    output logic       RES,
    output logic       BUSY
);
    localparam int AW = $clog2(FIFO_DEPTH);

    // Valid bits for stages S0..S3. Each stage keeps only the mask bits still ahead of it.
    logic [3:0]    s_v;
    logic [2:0]    s0_m;
    logic [2:1]    s1_m;
    logic          s2_a;

    logic          mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [AW+1:0] occ;
    logic          accept, push, pop;

    // Admission counts every operation in flight plus every result still buffered.
    // A pop in the same cycle is not credited, so the FIFO cannot overflow.
    assign occ = (AW+2)'(s_v[0]) + (AW+2)'(s_v[1]) + (AW+2)'(s_v[2]) + (AW+2)'(s_v[3])
               + (AW+2)'(count);
    assign REQ_RDY = occ < (AW+2)'(FIFO_DEPTH);
    assign accept  = REQ_V & REQ_RDY;
    assign push    = s_v[3];
    assign pop     = RES_V & RES_RDY;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            s_v  <= '0;
            s0_m <= '0;
            s1_m <= '0;
            s2_a <= 1'b0;
            D    <= 1'b1;
            E    <= 1'b1;
            C    <= 1'b0;
            B    <= 1'b0;
            A    <= 1'b0;
        end else begin
            s_v    <= {s_v[2:0], accept};
            s0_m   <= REQ_MASK;
            s1_m   <= s0_m[2:1];
            s2_a   <= s1_m[2];
            // The operand enters the NAND in the cycle right after the accept edge.
            {D, E} <= accept ? REQ_OP : 2'b11;
            C      <= s_v[0] & s0_m[0];
            B      <= s_v[1] & s1_m[1];
            A      <= s_v[2] & s2_a;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= OUT;
    end

    assign RES_V = (count != '0);
    assign RES   = RES_V & mem[rd_ptr];
    assign BUSY  = (|s_v) | RES_V;

endmodule

// File: tb/tb_vdf_3_seq.sv
// Directed bench for vdf_3_seq with a behavioural model of the gated DFF pipeline on OUT.
module tb_vdf_3_seq;
    logic       CLK = 1'b0;
    logic       RSTN = 1'b0;
    logic       REQ_V = 1'b0;
    logic       REQ_RDY;
    logic [1:0] REQ_OP = 2'b00;
    logic [2:0] REQ_MASK = 3'b000;
    logic       D, E, C, B, A;
    logic       OUT;
    logic       RES_V;
    logic       RES_RDY = 1'b0;
    logic       RES;
    logic       BUSY;

    int ncmp = 0;
    int nfail = 0;

    // External pipeline: NAND front, stage flops gated by C, B, then A on the output.
    logic q1, q2, q3;
    logic rand_en = 1'b0;
    logic rnd = 1'b0;
    always @(posedge CLK) begin
        q1 <= ~(D & E);
        q2 <= q1 & C;
        q3 <= q2 & B;
    end
    assign OUT = rand_en ? rnd : (A & q3);

    // Results for ops 00/01/10/11 with full mask.
    logic       exp4 [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    // Mask-gating slot tables, bit t = value after edge k+t.
    logic [6:0] c_tab = 7'b0000110;
    logic [6:0] b_tab = 7'b0010100;
    logic [6:0] a_tab = 7'b0110000;
    logic [6:0] v_tab = 7'b1110000;
    logic [6:0] d_tab = 7'b1111000;

    vdf_3_seq #(.FIFO_DEPTH(8)) dut (
        .CLK(CLK), .RSTN(RSTN), .REQ_V(REQ_V), .REQ_RDY(REQ_RDY), .REQ_OP(REQ_OP),
        .REQ_MASK(REQ_MASK), .D(D), .E(E), .C(C), .B(B), .A(A), .OUT(OUT),
        .RES_V(RES_V), .RES_RDY(RES_RDY), .RES(RES), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        rnd = 1'($urandom);
    endtask

    initial begin
        int acc;

        // Reset state
        step(); step();
        check("rst_de", {6'd0, D, E}, 8'h3);
        check("rst_abc", {5'd0, A, B, C}, 8'h0);
        check("rst_resv", {7'd0, RES_V}, 8'h0);
        check("rst_res", {7'd0, RES}, 8'h0);
        check("rst_busy", {7'd0, BUSY}, 8'h0);
        RSTN = 1'b1;
        check("rst_rdy", {7'd0, REQ_RDY}, 8'h1);
        step();

        // Single op 01 / 111
        REQ_V = 1'b1; REQ_OP = 2'b01; REQ_MASK = 3'b111;
        check("s_rdy", {7'd0, REQ_RDY}, 8'h1);
        step();
        REQ_V = 1'b0;
        check("s_de_k", {6'd0, D, E}, 8'h1);
        check("s_abc_k", {5'd0, A, B, C}, 8'h0);
        step();
        check("s_abc_k1", {5'd0, A, B, C}, 8'h1);
        check("s_de_k1", {6'd0, D, E}, 8'h3);
        step();
        check("s_abc_k2", {5'd0, A, B, C}, 8'h2);
        step();
        check("s_abc_k3", {5'd0, A, B, C}, 8'h4);
        check("s_resv_k3", {7'd0, RES_V}, 8'h0);
        step();
        check("s_resv_k4", {7'd0, RES_V}, 8'h1);
        check("s_res_k4", {7'd0, RES}, 8'h1);
        check("s_abc_k4", {5'd0, A, B, C}, 8'h0);
        check("s_busy_k4", {7'd0, BUSY}, 8'h1);
        RES_RDY = 1'b1;
        step();
        RES_RDY = 1'b0;
        check("s_resv_pop", {7'd0, RES_V}, 8'h0);
        check("s_busy_pop", {7'd0, BUSY}, 8'h0);

        // Streaming: 16 accepts, ops cycling 00..11, full mask
        RES_RDY = 1'b1;
        REQ_MASK = 3'b111;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc < 16) begin
                REQ_V = 1'b1;
                REQ_OP = 2'(cyc % 4);
                check("st_rdy", {7'd0, REQ_RDY}, 8'h1);
            end else begin
                REQ_V = 1'b0;
            end
            step();
            if (cyc >= 4) begin
                check("st_resv", {7'd0, RES_V}, 8'h1);
                check("st_res", {7'd0, RES}, {7'd0, exp4[(cyc - 4) % 4]});
            end else begin
                check("st_resv0", {7'd0, RES_V}, 8'h0);
            end
        end
        step();
        check("st_empty", {7'd0, RES_V}, 8'h0);
        check("st_busy", {7'd0, BUSY}, 8'h0);

        // Mask gating: op 01 with masks 011, 101, 110 back-to-back
        for (int t = 0; t < 7; t++) begin
            REQ_V = (t < 3);
            REQ_OP = 2'b01;
            REQ_MASK = (t == 0) ? 3'b011 : (t == 1) ? 3'b101 : 3'b110;
            step();
            check("mg_c", {7'd0, C}, {7'd0, c_tab[t]});
            check("mg_b", {7'd0, B}, {7'd0, b_tab[t]});
            check("mg_a", {7'd0, A}, {7'd0, a_tab[t]});
            check("mg_d", {7'd0, D}, {7'd0, d_tab[t]});
            check("mg_resv", {7'd0, RES_V}, {7'd0, v_tab[t]});
            if (v_tab[t]) check("mg_res", {7'd0, RES}, 8'h0);
        end
        REQ_V = 1'b0;
        step();
        check("mg_empty", {7'd0, RES_V}, 8'h0);

        // Backpressure: RES_RDY low, REQ_V held
        RES_RDY = 1'b0;
        REQ_MASK = 3'b111;
        acc = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            REQ_V = 1'b1;
            REQ_OP = 2'(acc % 4);
            check("bp_rdy", {7'd0, REQ_RDY}, (cyc < 8) ? 8'h1 : 8'h0);
            if (REQ_RDY) acc++;
            step();
        end
        REQ_V = 1'b0;
        check("bp_acc", 8'(acc), 8'd8);
        step(); step();
        check("bp_full_rdy", {7'd0, REQ_RDY}, 8'h0);
        check("bp_full_v", {7'd0, RES_V}, 8'h1);
        RES_RDY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("bp_pop_v", {7'd0, RES_V}, 8'h1);
            check("bp_pop_res", {7'd0, RES}, {7'd0, exp4[i % 4]});
            step();
            if (i == 0) check("bp_rdy_back", {7'd0, REQ_RDY}, 8'h1);
        end
        RES_RDY = 1'b0;
        check("bp_drained", {7'd0, RES_V}, 8'h0);
        check("bp_busy", {7'd0, BUSY}, 8'h0);
        check("bp_resume", {7'd0, REQ_RDY}, 8'h1);

        // Reset mid-flight
        REQ_V = 1'b1; REQ_OP = 2'b01; REQ_MASK = 3'b111;
        step(); step(); step();
        REQ_V = 1'b0;
        step();
        RSTN = 1'b0;
        #1;
        check("rm_abc", {5'd0, A, B, C}, 8'h0);
        check("rm_de", {6'd0, D, E}, 8'h3);
        check("rm_resv", {7'd0, RES_V}, 8'h0);
        check("rm_busy", {7'd0, BUSY}, 8'h0);
        step(); step();
        RSTN = 1'b1;
        check("rm_rdy", {7'd0, REQ_RDY}, 8'h1);
        for (int i = 0; i < 6; i++) begin
            step();
            check("rm_post_v", {7'd0, RES_V}, 8'h0);
            check("rm_post_abc", {5'd0, A, B, C}, 8'h0);
            check("rm_post_de", {6'd0, D, E}, 8'h3);
        end
        REQ_V = 1'b1; REQ_OP = 2'b10; REQ_MASK = 3'b111;
        step();
        REQ_V = 1'b0;
        step(); step(); step();
        check("rm_new_v3", {7'd0, RES_V}, 8'h0);
        step();
        check("rm_new_v", {7'd0, RES_V}, 8'h1);
        check("rm_new_res", {7'd0, RES}, 8'h1);
        RES_RDY = 1'b1;
        step();
        RES_RDY = 1'b0;
        check("rm_new_pop", {7'd0, RES_V}, 8'h0);

        // Idle after reset with random OUT
        RSTN = 1'b0;
        step();
        RSTN = 1'b1;
        rand_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_v", {7'd0, RES_V}, 8'h0);
            check("idle_busy", {7'd0, BUSY}, 8'h0);
            check("idle_rdy", {7'd0, REQ_RDY}, 8'h1);
        end
        rand_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
